// File: rtl/stream_check_sink.sv
// ---------------------------------------------------------------------------
// stream_check_sink
//
// Self-checking val/rdy sink for single-clock queue benches. Expected
// messages are preloaded into a small memory. A start then opens a check
// run in which every accepted message is compared, in order, with the
// preloaded values. The outcome is reported as done / pass / timeout plus a
// saturating mismatch count and the index of the first mismatch.
//
// Optional feature (compile-time macro):
//   STREAM_CHECK_SINK_RAND_STALL_EN
//     - defined:   a 16-bit Fibonacci LFSR (taps 16,14,13,11) throttles rdy
//                  during RUN (ready when lfsr[1:0] != 0, about 75%).
//     - undefined: rdy is high in every RUN cycle.
//
// Parameters
//   p_msg_nbits      width of one message
//   p_max_msgs       depth of the expected-message memory (power of 2)
//   p_cnt_nbits      width of err_count (saturating)
//   p_timeout_cycles idle RUN cycles without a handshake before timeout
//   p_seed           LFSR seed, nonzero (stall feature only)
//
// Ports
//   clk        in   bench clock
//   reset      in   asynchronous active-high reset
//   start      in   begin a check run (accepted in IDLE or DONE)
//   num_msgs   in   number of messages to expect, sampled on start
//   ld_en      in   write expected message (accepted in IDLE or DONE)
//   ld_addr    in   expected-memory write index
//   ld_data    in   expected message
//   msg        in   DUT output message
//   val        in   DUT output valid
//   rdy        out  sink ready (registered, independent of val)
//   done       out  run finished (completed or timed out)
//   pass       out  done with no mismatch and no timeout
//   timeout    out  run aborted by the idle timeout
//   err_count  out  saturating mismatch count
//   err_idx    out  index of the first mismatch
// ---------------------------------------------------------------------------
module stream_check_sink #(
  parameter int          p_msg_nbits      = 8,
  parameter int          p_max_msgs       = 64,
  parameter int          p_cnt_nbits      = 8,
  parameter int          p_timeout_cycles = 1000,
  parameter logic [15:0] p_seed           = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [$clog2(p_max_msgs):0]     num_msgs,
  input  logic                            ld_en,
  input  logic [$clog2(p_max_msgs)-1:0]   ld_addr,
  input  logic [p_msg_nbits-1:0]          ld_data,
  input  logic [p_msg_nbits-1:0]          msg,
  input  logic                            val,
  output logic                            rdy,
  output logic                            done,
  output logic                            pass,
  output logic                            timeout,
  output logic [p_cnt_nbits-1:0]          err_count,
  output logic [$clog2(p_max_msgs)-1:0]   err_idx
);

  localparam int AW = $clog2(p_max_msgs);
  localparam int NW = AW + 1;
  localparam int TW = $clog2(p_timeout_cycles + 1);

  localparam logic [NW-1:0]          MAX_N   = NW'(p_max_msgs);
  localparam logic [TW-1:0]          TO_LAST = TW'(p_timeout_cycles - 1);
  localparam logic [p_cnt_nbits-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturating increment of the mismatch counter.
  function automatic logic [p_cnt_nbits-1:0] sat_inc(input logic [p_cnt_nbits-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Clamp a requested message count to the memory depth.
  function automatic logic [NW-1:0] clamp_n(input logic [NW-1:0] n);
    return (n > MAX_N) ? MAX_N : n;
  endfunction

  state_t                   state, state_n;
  logic [NW-1:0]            idx, idx_n;
  logic [NW-1:0]            n_msgs, n_msgs_n;
  logic [TW-1:0]            idle_cnt, idle_cnt_n;
  logic [p_cnt_nbits-1:0]   err_count_n;
  logic [AW-1:0]            err_idx_n;
  logic                     timeout_n;
  logic                     done_n;
  logic                     pass_n;
  logic                     rdy_n;
  logic                     stall_rdy_n;

  logic                     accept;
  logic                     hs;
  logic                     mismatch;
  logic [p_msg_nbits-1:0]   exp_msg;

  logic [p_msg_nbits-1:0]   mem [p_max_msgs];

  // A start is honoured only outside RUN; loads follow the same rule, so a
  // load in the start cycle lands before the first compare of the new run.
  assign accept   = start && (state != RUN);
  assign hs       = (state == RUN) && val && rdy;
  assign exp_msg  = mem[idx[AW-1:0]];
  // Case inequality: an X/Z message bit is reported as a mismatch.
  assign mismatch = hs && (msg !== exp_msg);

  always_ff @(posedge clk) begin
    if (ld_en && (state != RUN)) begin
      mem[ld_addr] <= ld_data;
    end
  end

`ifdef STREAM_CHECK_SINK_RAND_STALL_EN
  logic [15:0] lfsr, lfsr_n;

  always_comb begin
    lfsr_n = lfsr;
    if (accept) begin
      lfsr_n = p_seed;
    end else if (state == RUN) begin
      lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // rdy is registered from the LFSR value it will sit beside next cycle, so
  // rdy in any RUN cycle equals (lfsr[1:0] != 0) for that cycle's LFSR.
  assign stall_rdy_n = (lfsr_n[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= p_seed;
    end else begin
      lfsr <= lfsr_n;
    end
  end
`else
  logic unused_seed;
  assign unused_seed = ^p_seed;
  assign stall_rdy_n = 1'b1;
`endif

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    n_msgs_n    = n_msgs;
    idle_cnt_n  = idle_cnt;
    err_count_n = err_count;
    err_idx_n   = err_idx;
    timeout_n   = timeout;
    done_n      = done;
    pass_n      = pass;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          idx_n       = '0;
          idle_cnt_n  = '0;
          err_count_n = '0;
          err_idx_n   = '0;
          timeout_n   = 1'b0;
          if (num_msgs == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
            pass_n  = 1'b1;
          end else begin
            state_n  = RUN;
            n_msgs_n = clamp_n(num_msgs);
            done_n   = 1'b0;
            pass_n   = 1'b0;
          end
        end
      end

      RUN: begin
        if (hs) begin
          idx_n      = idx + 1'b1;
          idle_cnt_n = '0;
          if (mismatch) begin
            err_count_n = sat_inc(err_count);
            if (err_count == '0) begin
              err_idx_n = idx[AW-1:0];
            end
          end
          if (idx == n_msgs - 1'b1) begin
            state_n = DONE;
            done_n  = 1'b1;
            pass_n  = (err_count_n == '0);
          end
        end else if (!val) begin
          // Only cycles with nothing offered count as idle; a stalled cycle
          // with val high is the sink's own doing and does not age the run.
          if (idle_cnt == TO_LAST) begin
            state_n   = DONE;
            timeout_n = 1'b1;
            done_n    = 1'b1;
            pass_n    = 1'b0;
          end else begin
            idle_cnt_n = idle_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    rdy_n = (state_n == RUN) && stall_rdy_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      n_msgs    <= '0;
      idle_cnt  <= '0;
      err_count <= '0;
      err_idx   <= '0;
      timeout   <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      rdy       <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      n_msgs    <= n_msgs_n;
      idle_cnt  <= idle_cnt_n;
      err_count <= err_count_n;
      err_idx   <= err_idx_n;
      timeout   <= timeout_n;
      done      <= done_n;
      pass      <= pass_n;
      rdy       <= rdy_n;
    end
  end

endmodule

// File: tb/tb_stream_check_sink.sv
// ---------------------------------------------------------------------------
// tb_stream_check_sink
//
// Bench for stream_check_sink. A behavioural model keeps its own copy of the
// expected memory and of the messages sent each run; the expected result of
// a run (mismatch count, first mismatch index, pass) is computed from those
// arrays once the run completes.
// ---------------------------------------------------------------------------
module tb_stream_check_sink;

  localparam int MW   = 8;
  localparam int MAXM = 64;
  localparam int CW   = 8;
  localparam int TO   = 1000;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   num_msgs;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [MW-1:0] ld_data;
  logic [MW-1:0] msg;
  logic          val;
  logic          rdy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [CW-1:0] err_count;
  logic [AW-1:0] err_idx;

  int n_chk = 0;
  int n_err = 0;
  int stall_cnt = 0;

  logic [7:0] model_mem [MAXM];
  logic [7:0] sent      [MAXM];

  always #5 clk = ~clk;

  stream_check_sink #(
    .p_msg_nbits     (MW),
    .p_max_msgs      (MAXM),
    .p_cnt_nbits     (CW),
    .p_timeout_cycles(TO),
    .p_seed          (16'hACE1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_msgs (num_msgs),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .msg      (msg),
    .val      (val),
    .rdy      (rdy),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
    .err_count(err_count),
    .err_idx  (err_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a[AW-1:0];
    ld_data = d;
    tick();
    ld_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic do_start(input int n);
    start    = 1'b1;
    num_msgs = n[AW:0];
    tick();
    start = 1'b0;
  endtask

  // Offer one message after 'gap' empty cycles and hold it until taken.
  task automatic send(input logic [7:0] m, input int gap);
    int   guard;
    logic took;
    for (int g = 0; g < gap; g++) tick();
    val   = 1'b1;
    msg   = m;
    guard = 0;
    took  = 1'b0;
    while (!took && guard < 300) begin
      took = rdy;
      if (!rdy) stall_cnt++;
      tick();
      guard++;
    end
    val = 1'b0;
    if (!took) chk("hs_wait", 32'd0, 32'd1);
  endtask

  // Expected outcome of a completed run from the model arrays.
  task automatic expect_result(input string tag, input int n);
    int e     = 0;
    int first = 0;
    for (int i = 0; i < n; i++) begin
      if (sent[i] != model_mem[i]) begin
        if (e == 0) first = i;
        if (e < 255) e++;
      end
    end
    chk({tag, "_done"},    done,      32'd1);
    chk({tag, "_pass"},    pass,      (e == 0) ? 32'd1 : 32'd0);
    chk({tag, "_errcnt"},  err_count, e);
    chk({tag, "_erridx"},  err_idx,   first);
    chk({tag, "_timeout"}, timeout,   32'd0);
    chk({tag, "_rdy"},     rdy,       32'd0);
  endtask

  task automatic run(input string tag, input int n_req, input int gap_max);
    int n_eff;
    n_eff = (n_req > MAXM) ? MAXM : n_req;
    do_start(n_req);
    chk({tag, "_busy"}, done, 32'd0);
    for (int i = 0; i < n_eff; i++) begin
      if (i == n_eff - 1) chk({tag, "_predone"}, done, 32'd0);
      send(sent[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    end
    expect_result(tag, n_eff);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rdy"},     rdy,       32'd0);
    chk({tag, "_done"},    done,      32'd0);
    chk({tag, "_pass"},    pass,      32'd0);
    chk({tag, "_timeout"}, timeout,   32'd0);
    chk({tag, "_errcnt"},  err_count, 32'd0);
    chk({tag, "_erridx"},  err_idx,   32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int n;
    logic [7:0] a_val, b_val, c_val;

    reset    = 1'b1;
    start    = 1'b0;
    num_msgs = '0;
    ld_en    = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    msg      = '0;
    val      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();
    check_idle_outputs("post_reset");

    // Matching stream, back to back.
    load(0, 8'h11); load(1, 8'h22); load(2, 8'h33);
    sent[0] = 8'h11; sent[1] = 8'h22; sent[2] = 8'h33;
    run("match3", 3, 0);

    // One corrupted message in the middle.
    sent[1] = 8'h99;
    run("bad_mid", 3, 0);

    // Zero-length run right after a failing one.
    do_start(0);
    chk("zero_done",   done,      32'd1);
    chk("zero_pass",   pass,      32'd1);
    chk("zero_errcnt", err_count, 32'd0);
    c = 0;
    for (int i = 0; i < 4; i++) begin
      if (rdy) c++;
      tick();
    end
    chk("zero_rdy", c, 32'd0);

    // Timeout after the first of two messages.
    do_start(2);
    send(model_mem[0], 0);
    chk("to_early", done, 32'd0);
    c = 0;
    while (!done && c < 1200) begin
      tick();
      c++;
    end
    chk("to_timeout", timeout, 32'd1);
    chk("to_done",    done,    32'd1);
    chk("to_pass",    pass,    32'd0);
    chk("to_window",  (c >= TO - 2 && c <= TO + 2) ? 32'd1 : 32'd0, 32'd1);
    chk("to_rdy",     rdy,     32'd0);

    // Reset in the middle of a run with a mismatch already counted.
    load(3, 8'h44);
    do_start(4);
    send(model_mem[0] ^ 8'hFF, 0);
    send(model_mem[1], 0);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    tick();
    reset = 1'b0;
    tick();
    check_idle_outputs("after_reset");
    for (int i = 0; i < 4; i++) sent[i] = model_mem[i];
    run("restart4", 4, 1);

    // Load and start ignored while running.
    a_val = 8'($urandom_range(0, 255));
    b_val = 8'($urandom_range(0, 255));
    load(0, a_val); load(1, b_val);
    sent[0] = a_val; sent[1] = b_val;
    do_start(2);
    ld_en = 1'b1; ld_addr = '0; ld_data = ~a_val;
    start = 1'b1; num_msgs = '0;
    tick();
    ld_en = 1'b0; start = 1'b0;
    chk("ign_busy", done, 32'd0);
    send(sent[0], 0);
    send(sent[1], 0);
    expect_result("ign", 2);

    // Load in the same cycle as start.
    c_val = ~a_val;
    ld_en = 1'b1; ld_addr = '0; ld_data = c_val;
    start = 1'b1; num_msgs = 7'd1;
    tick();
    ld_en = 1'b0; start = 1'b0;
    model_mem[0] = c_val;
    sent[0] = c_val;
    send(sent[0], 0);
    expect_result("ldstart", 1);

    // Oversized request clamps to full depth; val held high throughout.
    for (int i = 0; i < MAXM; i++) begin
      load(i, 8'($urandom_range(0, 255)));
      sent[i] = model_mem[i];
    end
    stall_cnt = 0;
    run("clamp", 100, 0);
`ifdef STREAM_CHECK_SINK_RAND_STALL_EN
    chk("stall_seen", (stall_cnt > 0) ? 32'd1 : 32'd0, 32'd1);
`else
    chk("no_stall", stall_cnt, 32'd0);
`endif

    // Randomized runs with random corruption and gaps.
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, MAXM));
      for (int i = 0; i < n; i++) begin
        load(i, 8'($urandom_range(0, 255)));
        if ($urandom_range(0, 3) == 0)
          sent[i] = model_mem[i] ^ 8'($urandom_range(1, 255));
        else
          sent[i] = model_mem[i];
      end
      run($sformatf("rand%0d", r), n, 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
